// File: rtl/req_priority_arbiter_if.sv
// Request/grant bundle between the 16 requesters and req_priority_arbiter.
// The master side drives requests and the mode; the slave side (the arbiter) returns the grant.
interface req_priority_arbiter_if;
    logic [15:0] req;
    logic        rr_mode;
    logic [15:0] gnt;
    logic [3:0]  gnt_id;
    logic        gnt_valid;
    logic [7:0]  status;

    modport master (
        output req,
        output rr_mode,
        input  gnt,
        input  gnt_id,
        input  gnt_valid,
        input  status
    );

    modport slave (
        input  req,
        input  rr_mode,
        output gnt,
        output gnt_id,
        output gnt_valid,
        output status
    );
endinterface

// File: rtl/req_priority_arbiter.sv
// 16-way fixed-priority / round-robin arbiter with a registered one-hot grant held until release.
// Optional per-owner hold limit is compiled in with `define ARB_HOLD_LIMIT_EN.
module req_priority_arbiter #(
    parameter int unsigned NREQ     = 16,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    req_priority_arbiter_if.slave  bus
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t      state_r;
    logic [15:0] gnt_r;
    logic [3:0]  gnt_id_r;
    logic [3:0]  last_id_r;
    logic        gnt_valid_r;
    logic [7:0]  status_r;

    logic        decide_s;
    logic        hold_expired_s;
    logic [15:0] cand_s;
    logic [3:0]  start_s;
    logic [4:0]  pick_s;

    function automatic logic [15:0] id_onehot(input logic [3:0] id);
        return 16'h0001 << id;
    endfunction

    // Returns {found, index} of the first set bit scanning down from start, wrapping 0 -> 15.
    function automatic logic [4:0] scan_desc(input logic [15:0] vec, input logic [3:0] start);
        logic [4:0] res;
        logic [3:0] idx;
        res = 5'd0;
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            idx = start - 4'(k);
            if (vec[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // An out-of-range MAX_HOLD shows up as a named block in the elaborated hierarchy.
    if ((MAX_HOLD < 32'd2) || (MAX_HOLD > 32'd255)) begin : g_max_hold_out_of_range
    end

`ifdef ARB_HOLD_LIMIT_EN
    localparam logic [7:0] HOLD_MAX  = 8'(MAX_HOLD);
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 32'd1);

    logic [7:0] hold_cnt_r;

    assign hold_expired_s = (hold_cnt_r >= HOLD_LAST) &&
                            ((bus.req & ~id_onehot(gnt_id_r)) != 16'h0000);

    // Tenure counter: cleared by every decision, saturating while the owner keeps the grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_r <= 8'd0;
        end else if (decide_s) begin
            hold_cnt_r <= 8'd0;
        end else if ((state_r == ST_GRANT) && (hold_cnt_r < HOLD_MAX)) begin
            hold_cnt_r <= hold_cnt_r + 8'd1;
        end
    end
`else
    assign hold_expired_s = 1'b0;
`endif

    // Decision condition, candidate set (owner always masked while granted) and winner search.
    always_comb begin
        decide_s = 1'b0;
        cand_s   = 16'h0000;
        start_s  = 4'hF;
        pick_s   = 5'd0;
        if (state_r == ST_IDLE) begin
            decide_s = 1'b1;
            cand_s   = bus.req;
        end else begin
            decide_s = !bus.req[gnt_id_r] || hold_expired_s;
            cand_s   = bus.req & ~id_onehot(gnt_id_r);
        end
        if (bus.rr_mode) begin
            start_s = last_id_r - 4'd1;
        end else begin
            start_s = 4'hF;
        end
        pick_s = scan_desc(cand_s, start_s);
    end

    // Grant state and registered outputs; gnt_id and last_id survive an empty decision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            gnt_r       <= 16'h0000;
            gnt_id_r    <= 4'd0;
            last_id_r   <= 4'd0;
            gnt_valid_r <= 1'b0;
            status_r    <= 8'hF0;
        end else if (decide_s) begin
            if (pick_s[4]) begin
                state_r     <= ST_GRANT;
                gnt_r       <= id_onehot(pick_s[3:0]);
                gnt_id_r    <= pick_s[3:0];
                last_id_r   <= pick_s[3:0];
                gnt_valid_r <= 1'b1;
                status_r    <= {1'b1, 3'b000, pick_s[3:0]};
            end else begin
                state_r     <= ST_IDLE;
                gnt_r       <= 16'h0000;
                gnt_valid_r <= 1'b0;
                status_r    <= 8'hF0;
            end
        end
    end

    assign bus.gnt       = gnt_r;
    assign bus.gnt_id    = gnt_id_r;
    assign bus.gnt_valid = gnt_valid_r;
    assign bus.status    = status_r;

endmodule

// File: tb/tb_req_priority_arbiter.sv
// Directed plus randomized bench for req_priority_arbiter against a tenure-based reference model.
module tb_req_priority_arbiter;

    localparam int MAX_HOLD = 4;

    logic clk;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: owner (-1 when idle), retained id, rotation pointer, cycles held so far.
    int m_owner;
    int m_id;
    int m_last;
    int m_tenure;

    req_priority_arbiter_if bus ();

    req_priority_arbiter #(.NREQ(16), .MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_pick(input logic [15:0] c, input logic rr, input int last);
        if (!rr) begin
            for (int i = 15; i >= 0; i--) if (c[i]) return i;
            return -1;
        end
        for (int k = 1; k <= 16; k++) begin
            int idx;
            idx = (last - k + 16) % 16;
            if (c[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner  = -1;
        m_id     = 0;
        m_last   = 0;
        m_tenure = 0;
    endtask

    task automatic model_step(input logic [15:0] r, input logic m);
        logic [15:0] others;
        bit          decide;
        int          w;
        others = r;
        if (m_owner < 0) begin
            decide = 1'b1;
        end else begin
            others[m_owner] = 1'b0;
            decide = !r[m_owner];
`ifdef ARB_HOLD_LIMIT_EN
            if (m_tenure >= MAX_HOLD && others != 16'h0000) decide = 1'b1;
`endif
        end
        if (decide) begin
            w = model_pick(others, m, m_last);
            if (w >= 0) begin
                m_owner  = w;
                m_id     = w;
                m_last   = w;
                m_tenure = 1;
            end else begin
                m_owner  = -1;
                m_tenure = 0;
            end
        end else begin
            m_tenure++;
        end
    endtask

    task automatic check_outputs(input string ph);
        logic [15:0] eg;
        logic [7:0]  es;
        eg = (m_owner >= 0) ? (16'h0001 << m_owner) : 16'h0000;
        es = (m_owner >= 0) ? {4'h8, 4'(m_id)} : 8'hF0;
        check_eq({ph, "_gnt"},    32'(bus.gnt),       32'(eg));
        check_eq({ph, "_id"},     32'(bus.gnt_id),    32'(m_id));
        check_eq({ph, "_valid"},  32'(bus.gnt_valid), (m_owner >= 0) ? 32'd1 : 32'd0);
        check_eq({ph, "_status"}, 32'(bus.status),    32'(es));
    endtask

    task automatic step(input string ph, input logic [15:0] r, input logic m);
        bus.req     = r;
        bus.rr_mode = m;
        model_step(r, m);
        @(posedge clk);
        #1;
        check_outputs(ph);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        #12;
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int          rr_seq [6];
        logic [15:0] r;
        logic        m;
        rr_seq = '{4, 1, 0, 4, 1, 0};

        bus.req     = 16'h0000;
        bus.rr_mode = 1'b0;
        rst_n       = 1'b1;
        #2;
        apply_reset();
        check_eq("reset_status_const", 32'(bus.status), 32'h0000_00F0);

        step("idle", 16'h0000, 1'b0);

        // Fixed priority, then release of the top bit hands over without a gap.
        step("fix", 16'h8421, 1'b0);
        check_eq("fix_gnt_8000", 32'(bus.gnt), 32'h0000_8000);
        check_eq("fix_status_8f", 32'(bus.status), 32'h0000_008F);
        step("fix", 16'h0421, 1'b0);
        check_eq("fix_id_10", 32'(bus.gnt_id), 32'd10);

        // Round-robin rotation over bits 4,1,0 with each owner releasing after two cycles.
        for (int i = 0; i < 6; i++) begin
            r = 16'h0013;
            if (i > 0) r[rr_seq[i-1]] = 1'b0;
            step("rr", r, 1'b1);
            check_eq("rr_order", 32'(bus.gnt_id), 32'(rr_seq[i]));
            step("rr", 16'h0013, 1'b1);
            check_eq("rr_hold", 32'(bus.gnt_id), 32'(rr_seq[i]));
        end

        // Hold: bit 9 waits until bit 0 lets go.
        step("hold", 16'h0000, 1'b0);
        step("hold", 16'h0001, 1'b0);
        step("hold", 16'h0201, 1'b0);
        check_eq("hold_keep0", 32'(bus.gnt_id), 32'd0);
        step("hold", 16'h0201, 1'b0);
        check_eq("hold_keep0", 32'(bus.gnt_id), 32'd0);
        step("hold", 16'h0200, 1'b0);
        check_eq("hold_then9", 32'(bus.gnt_id), 32'd9);

        // Asynchronous reset between clock edges.
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_gnt", 32'(bus.gnt), 32'd0);
        check_eq("async_valid", 32'(bus.gnt_valid), 32'd0);
        check_eq("async_status", 32'(bus.status), 32'h0000_00F0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Two requesters held constant in round-robin; alternate only when the hold limit exists.
        for (int k = 1; k <= 12; k++) begin
            step("lim", 16'h0006, 1'b1);
`ifdef ARB_HOLD_LIMIT_EN
            check_eq("lim_owner", 32'(bus.gnt_id), (((k - 1) / 4) % 2 == 0) ? 32'd2 : 32'd1);
`else
            check_eq("lim_owner", 32'(bus.gnt_id), 32'd2);
`endif
        end
        for (int k = 0; k < 6; k++) begin
            step("lim_solo", 16'h0004, 1'b1);
            check_eq("lim_solo_owner", 32'(bus.gnt_id), 32'd2);
        end
        step("lim_join", 16'h0005, 1'b1);

        // Randomized traffic with sparse requests and occasional mode changes.
        m = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 7) == 0) m = ~m;
            r = 16'($urandom() & $urandom() & $urandom());
            if ($urandom_range(0, 3) == 0) r = bus.req;
            step("rand", r, m);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
